layer_output_streamer: RTL and testbench
========================================

Name: layer_output_streamer

Overview:
- Reader-side counterpart to a decoder output layer. It waits for the layer's done, then walks the layer's output BRAM read port over addresses 0..TOTAL_WORDS-1.
- It presents the words as a valid/ready stream with a last flag, for the host/DMA side of the accelerator.
- BRAM read latency is hidden by a credit-controlled skid FIFO, so stream backpressure never drops or duplicates a word.

Parameters:
- DATA_WIDTH, 20, word width (integer_width+fraction_width, Q10.10).
- FRACTION_WIDTH, 10, fraction bits of the BRAM word (used only by the optional feature).
- ADDR_WIDTH, 10, BRAM read address width.
- TOTAL_WORDS, 900, words per frame (30x30 decoder output).
- READ_LATENCY, 2, cycles from rd_en/rd_addr to valid rd_data (legal range 1..4).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- layer_done  in  1  level; high once the producing layer has finished writing its BRAM
- rd_addr  out  ADDR_WIDTH  BRAM read address
- rd_en  out  1  BRAM read enable, one word per asserted cycle
- rd_data  in  DATA_WIDTH  BRAM read data, valid READ_LATENCY cycles after rd_en
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_WIDTH  stream word (OUT_WIDTH=DATA_WIDTH, or 8 with the optional feature)
- m_last  out  1  high with the word from address TOTAL_WORDS-1
- busy  out  1  high in STREAM and DRAIN
- done  out  1  high in DONE

Behaviour:
- Reset values (asynchronous): rd_addr=0, rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, state=IDLE, FIFO empty, credits=0.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE -> STREAM when layer_done=1; rd_addr is cleared to 0.
- STREAM issues reads:
  - rd_en=1 in any cycle where (in_flight + fifo_count) < FIFO_DEPTH, with FIFO_DEPTH = READ_LATENCY+2.
  - rd_addr increments after each issued read.
  - After issuing address TOTAL_WORDS-1: rd_en=0 next cycle, move to DRAIN.
- In-flight tracking:
  - A READ_LATENCY-deep shift register of valid bits, plus one last bit, follows each issued read.
  - When a valid bit emerges, rd_data is pushed into the FIFO together with its last bit.
  - The FIFO is never full at a push; this is guaranteed by the credit rule and must be covered by an assertion.
- Stream handshake:
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
  - A word transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never deasserts without a transfer.
- Push and pop in the same cycle are legal; count is unchanged. Push into an empty FIFO makes the word visible next cycle (FIFO adds 1 cycle).
- Latency: first m_valid appears READ_LATENCY+2 cycles after the IDLE->STREAM transition cycle.
- Throughput: with m_ready held at 1, one word per cycle sustained.
- DRAIN -> DONE when the word with m_last transfers. DONE: done=1, busy=0, no reads.
- DONE -> IDLE when layer_done=0; the next frame needs layer_done low then high again. layer_done staying high does not restart.
- layer_done dropping during STREAM/DRAIN is ignored; the frame completes.
- Reset mid-frame: everything returns to reset values immediately, in-flight reads are discarded, and no partial m_last is emitted.
- Address counter width is ADDR_WIDTH; TOTAL_WORDS <= 2^ADDR_WIDTH. No wrap-around past TOTAL_WORDS-1.

Optional Feature:
- Macro PIXEL_QUANT_EN.
- Defined: OUT_WIDTH=8, and each word is quantized on FIFO push.
  - Sign bit set -> 0.
  - Any integer bit set (value >= 1.0) -> 255.
  - Otherwise -> bits [FRACTION_WIDTH-1 : FRACTION_WIDTH-8], truncated.
- Undefined: OUT_WIDTH=DATA_WIDTH and the raw BRAM word passes unchanged.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package (layer_stream_pkg):
  - state encoding localparams (IDLE=0, STREAM=1, DRAIN=2, DONE=3);
  - FIFO_DEPTH derivation;
  - the 8-bit quantization function.
- One sub-module: stream_skid_fifo (parameterized depth/width, push/pop/count/full/empty, synchronous, async reset).
- Credit/issue logic stays in the top.

Test Plan:
- READ_LATENCY=2, BRAM model holds data=address, m_ready=1, layer_done raised at cycle 0 -> 900 words 0..899 in order on consecutive cycles, m_last only on 899, done=1 the cycle after, first m_valid at cycle 4.
- Same, with m_ready toggled by a random 30% duty -> all 900 words exactly once in order, m_data stable while stalled, FIFO-overflow assertion never fires, rd_en idle while credits are exhausted.
- m_ready=0 for 20 cycles after start -> exactly FIFO_DEPTH=4 reads issued, m_valid=1 holding word 0, then releasing ready resumes from word 0.
- Reset pulsed after word 100 transfers -> next cycle all outputs at reset values. Re-raising layer_done restarts at address 0 with no stale words.
- layer_done held high after DONE -> no second frame. Drop then raise -> second complete 900-word frame.
- PIXEL_QUANT_EN build, BRAM words 0x00200 (0.5), 0x00400 (1.0), 0xFFC00 (negative), 0x003FF -> m_data 128, 255, 0, 255.

Source files
------------

// File: rtl/layer_stream_pkg.sv
// Shared definitions for the layer output streamer: FSM encoding, skid FIFO sizing
// and the 8-bit pixel quantizer used when PIXEL_QUANT_EN is defined.
package layer_stream_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // Room for every read that can be in the BRAM pipe plus one word of slack
   // in each direction, which keeps a sustained one-word-per-cycle stream.
   function automatic int unsigned fifo_depth(input int unsigned read_latency);
      return read_latency + 2;
   endfunction

   // Signed fixed-point word to 0..255: negative -> 0, >= 1.0 -> 255,
   // otherwise the top 8 fraction bits (truncated).
   function automatic logic [7:0] quantize_pixel(input logic [63:0]   word,
                                                 input int unsigned   data_width,
                                                 input int unsigned   fraction_width);
      logic [63:0] sign_s;
      logic [63:0] int_mask;
      logic [63:0] int_s;
      logic [63:0] frac_s;
      sign_s   = word >> (data_width - 1);
      int_mask = (64'd1 << (data_width - 1 - fraction_width)) - 64'd1;
      int_s    = (word >> fraction_width) & int_mask;
      frac_s   = (word >> (fraction_width - 8)) & 64'hFF;
      if ((sign_s & 64'd1) != 64'd0) begin
         return 8'd0;
      end
      if (int_s != 64'd0) begin
         return 8'd255;
      end
      return 8'(frac_s);
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO with count/full/empty; head word is visible while not empty.
module stream_skid_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 21,
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH),
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head_data,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 full,
   output logic                 empty
);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 push_ok;
   logic                 pop_ok;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
   endfunction

   assign full      = (count == CNT_WIDTH'(DEPTH));
   assign empty     = (count == '0);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/layer_output_streamer.sv
// Walks a finished layer's output BRAM and streams it out as valid/ready with last.
// Build option PIXEL_QUANT_EN: quantize each word to an 8-bit pixel on FIFO entry.
module layer_output_streamer
   import layer_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 20,
   parameter int unsigned FRACTION_WIDTH = 10,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned TOTAL_WORDS    = 900,
   parameter int unsigned READ_LATENCY   = 2,
`ifdef PIXEL_QUANT_EN
   localparam int unsigned OUT_WIDTH     = 8
`else
   localparam int unsigned OUT_WIDTH     = DATA_WIDTH
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  layer_done,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
   localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned USED_WIDTH = CNT_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_WORDS - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("layer_output_streamer: READ_LATENCY must be 1..4");
   end
   if (64'(TOTAL_WORDS) > (64'd1 << ADDR_WIDTH) || TOTAL_WORDS == 0) begin : g_bad_total
      $error("layer_output_streamer: TOTAL_WORDS must fit the address range");
   end
   if (FRACTION_WIDTH < 8 || FRACTION_WIDTH >= DATA_WIDTH) begin : g_bad_fraction
      $error("layer_output_streamer: FRACTION_WIDTH must be 8..DATA_WIDTH-1");
   end

   logic [1:0]              state;
   logic [1:0]              state_next;
   logic                    rd_en_next;
   logic [ADDR_WIDTH-1:0]   rd_addr_next;
   logic [READ_LATENCY-1:0] vld_sr;
   logic [READ_LATENCY-1:0] last_sr;
   logic [USED_WIDTH-1:0]   used;
   logic                    credit_ok;
   logic                    push;
   logic                    pop;
   logic [OUT_WIDTH-1:0]    push_word;
   logic [OUT_WIDTH:0]      fifo_head;
   logic [CNT_WIDTH-1:0]    fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign push = vld_sr[READ_LATENCY-1];
   assign pop  = m_valid && m_ready;

`ifdef PIXEL_QUANT_EN
   assign push_word = quantize_pixel(64'(rd_data), DATA_WIDTH, FRACTION_WIDTH);
`else
   assign push_word = rd_data;
`endif

   // Credits: reads in the BRAM pipe plus words parked in the FIFO, less a word leaving now.
   always_comb begin
      used = USED_WIDTH'(fifo_count) + USED_WIDTH'(rd_en);
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
         used = used + USED_WIDTH'(vld_sr[i]);
      end
      credit_ok = (used - USED_WIDTH'(pop)) < USED_WIDTH'(FIFO_DEPTH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      rd_en_next   = 1'b0;
      rd_addr_next = rd_addr;
      case (state)
         IDLE: begin
            if (layer_done) begin
               state_next   = STREAM;
               rd_en_next   = 1'b1;
               rd_addr_next = '0;
            end
         end
         STREAM: begin
            if (rd_en && rd_addr == LAST_ADDR) begin
               state_next = DRAIN;
            end else begin
               rd_en_next = credit_ok;
               if (rd_en) begin
                  rd_addr_next = rd_addr + ADDR_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!layer_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         vld_sr  <= '0;
         last_sr <= '0;
      end else begin
         rd_en   <= rd_en_next;
         rd_addr <= rd_addr_next;
         busy    <= (state_next == STREAM) || (state_next == DRAIN);
         done    <= (state_next == DONE);
         vld_sr  <= (vld_sr << 1) | READ_LATENCY'(rd_en);
         last_sr <= (last_sr << 1) | READ_LATENCY'(rd_en && rd_addr == LAST_ADDR);
      end
   end

   stream_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OUT_WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({last_sr[READ_LATENCY-1], push_word}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign m_valid = !fifo_empty;
   assign m_last  = fifo_head[OUT_WIDTH];
   assign m_data  = fifo_head[OUT_WIDTH-1:0];

   // The credit rule must leave a free slot for every word that emerges from the BRAM.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> !fifo_full);

endmodule

// File: tb/tb_layer_output_streamer.sv
// Self-checking bench for layer_output_streamer: BRAM model, stream scoreboard, corner cases.
module tb_layer_output_streamer;

   localparam int DW    = 20;
   localparam int FW    = 10;
   localparam int AW    = 10;
   localparam int TOTAL = 900;
   localparam int RL    = 2;
   localparam int DEPTH = RL + 2;
`ifdef PIXEL_QUANT_EN
   localparam int OUT_W = 8;
`else
   localparam int OUT_W = DW;
`endif

   logic              clk;
   logic              reset;
   logic              layer_done;
   logic [AW-1:0]     rd_addr;
   logic              rd_en;
   logic [DW-1:0]     rd_data;
   logic              m_valid;
   logic              m_ready;
   logic [OUT_W-1:0]  m_data;
   logic              m_last;
   logic              busy;
   logic              done;

   layer_output_streamer #(
      .DATA_WIDTH     (DW),
      .FRACTION_WIDTH (FW),
      .ADDR_WIDTH     (AW),
      .TOTAL_WORDS    (TOTAL),
      .READ_LATENCY   (RL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .layer_done (layer_done),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] word;
      int            quant;
   } qvec_t;

   qvec_t vec [8];
   bit    table_mode;

   int checks;
   int fails;
   int cyc;
   int exp_idx;
   int issued;
   int first_valid;
   int last_xfer;
   int done_seen;
   int ready_pct;
   bit strict_rate;
   bit stall_prev;
   int stall_data;
   bit stall_last;
   int cap [8];

   function automatic logic [DW-1:0] bram_word(input int a);
      if (table_mode && a >= 0 && a < 8) return vec[a[2:0]].word;
      return DW'(a);
   endfunction

   // Expected stream word for a BRAM word, written from the pixel rules directly.
   function automatic int ref_out(input logic [DW-1:0] w);
`ifdef PIXEL_QUANT_EN
      int v;
      v = int'(w);
      if (v >= (1 << (DW - 1))) return 0;
      if (v >= (1 << FW)) return 255;
      return v / (1 << (FW - 8));
`else
      return int'(w);
`endif
   endfunction

   // BRAM: fixed-latency read pipe; garbage on idle cycles.
   logic [DW-1:0] bram_pipe [RL];
   always @(posedge clk) begin
      bram_pipe[0] <= rd_en ? bram_word(int'(rd_addr)) : DW'(20'hABCDE);
      for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign rd_data = bram_pipe[RL-1];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_addr"}, int'(rd_addr), 0);
      check({tag, "_rd_en"},   int'(rd_en),   0);
      check({tag, "_m_valid"}, int'(m_valid), 0);
      check({tag, "_m_data"},  int'(m_data),  0);
      check({tag, "_m_last"},  int'(m_last),  0);
      check({tag, "_busy"},    int'(busy),    0);
      check({tag, "_done"},    int'(done),    0);
   endtask

   task automatic monitor();
      if (rd_en) begin
         check("rd_addr_order", int'(rd_addr), issued);
         issued++;
         check("credit_bound", int'((issued - exp_idx) <= DEPTH), 1);
      end
      if (stall_prev) begin
         check("hold_valid", int'(m_valid), 1);
         check("hold_data",  int'(m_data),  stall_data);
         check("hold_last",  int'(m_last),  int'(stall_last));
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
         check("data", int'(m_data), ref_out(bram_word(exp_idx)));
         check("last", int'(m_last), int'(exp_idx == TOTAL - 1));
         if (strict_rate) check("rate", cyc, first_valid + exp_idx);
         if (exp_idx < 8) cap[exp_idx] = int'(m_data);
         if (exp_idx == TOTAL - 1) last_xfer = cyc;
         exp_idx++;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = int'(m_data);
      stall_last = m_last;
      if (done && done_seen < 0) done_seen = cyc;
   endtask

   task automatic step();
      @(negedge clk);
      m_ready = ($urandom_range(99) < ready_pct);
      #1;
      cyc++;
      monitor();
   endtask

   // Raise layer_done in the current cycle; that cycle is cycle 0.
   task automatic start_frame(input int pct, input bit strict);
      exp_idx     = 0;
      issued      = 0;
      stall_prev  = 1'b0;
      first_valid = -1;
      last_xfer   = -1;
      done_seen   = -1;
      cyc         = 0;
      ready_pct   = pct;
      strict_rate = strict;
      layer_done  = 1'b1;
   endtask

   task automatic finish_frame(input int budget);
      while (done_seen < 0 && cyc < budget) step();
      check("frame_done_in_budget", int'(done_seen >= 0), 1);
      check("frame_words", exp_idx, TOTAL);
      check("done_after_last", done_seen, last_xfer + 1);
      check("busy_in_done", int'(busy), 0);
      check("rd_en_in_done", int'(rd_en), 0);
      check("valid_in_done", int'(m_valid), 0);
   endtask

   task automatic drop_layer_done();
      layer_done = 1'b0;
      step();
      check("done_cleared", int'(done), 0);
      check("busy_idle", int'(busy), 0);
   endtask

   initial begin
      vec[0] = '{20'h00200, 128};
      vec[1] = '{20'h00400, 255};
      vec[2] = '{20'hFFC00, 0};
      vec[3] = '{20'h003FF, 255};
      vec[4] = '{20'h00001, 0};
      vec[5] = '{20'h0007F, 31};
      vec[6] = '{20'h7FFFF, 255};
      vec[7] = '{20'h80000, 0};

      checks     = 0;
      fails      = 0;
      cyc        = 0;
      table_mode = 1'b0;
      ready_pct  = 100;
      reset      = 1'b1;
      layer_done = 1'b0;
      m_ready    = 1'b0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step();

      // Full-rate frame: first valid at cycle 4, one word per cycle.
      start_frame(100, 1'b1);
      finish_frame(1200);
      check("first_valid_latency", first_valid, RL + 2);
      check("last_xfer_cycle", last_xfer, RL + 2 + TOTAL - 1);
      drop_layer_done();

      // Random backpressure, ready high about 30% of cycles.
      start_frame(30, 1'b0);
      finish_frame(8000);
      drop_layer_done();

      // Ready held low: credits cap reads at FIFO depth, word 0 parked at the head.
      start_frame(0, 1'b0);
      repeat (20) step();
      check("stall_reads_issued", issued, DEPTH);
      check("stall_valid", int'(m_valid), 1);
      check("stall_head", int'(m_data), ref_out(bram_word(0)));
      check("stall_no_xfer", exp_idx, 0);
      ready_pct = 100;
      finish_frame(1500);
      drop_layer_done();

      // Reset right after word 100 transfers, then a clean restart.
      start_frame(100, 1'b0);
      while (exp_idx < 101 && cyc < 2000) step();
      check("reached_word_100", exp_idx, 101);
      @(posedge clk);
      #1;
      reset      = 1'b1;
      layer_done = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset      = 1'b0;
      stall_prev = 1'b0;
      repeat (5) begin
         step();
         check("post_reset_valid", int'(m_valid), 0);
         check("post_reset_rd_en", int'(rd_en), 0);
      end
      start_frame(100, 1'b1);
      finish_frame(1200);
      check("restart_first_valid", first_valid, RL + 2);

      // layer_done still high after DONE: no second frame.
      begin
         int extra_reads;
         int valid_seen;
         extra_reads = 0;
         valid_seen  = 0;
         repeat (30) begin
            step();
            extra_reads += int'(rd_en);
            valid_seen  += int'(m_valid);
         end
         check("hold_no_reads", extra_reads, 0);
         check("hold_no_valid", valid_seen, 0);
         check("hold_done", int'(done), 1);
      end
      drop_layer_done();
      start_frame(100, 1'b1);
      finish_frame(1200);
      drop_layer_done();

      // Table frame: first eight BRAM words from the vector table.
      table_mode = 1'b1;
      start_frame(100, 1'b1);
      finish_frame(1200);
      for (int i = 0; i < 8; i++) begin
`ifdef PIXEL_QUANT_EN
         check($sformatf("table_%0d", i), cap[i], vec[i].quant);
`else
         check($sformatf("table_%0d", i), cap[i], int'(vec[i].word));
`endif
      end
      drop_layer_done();
      table_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
